// File: rtl/acesso_memoria_pkg.sv
// Shared definitions for the memory-access stage: op codes, FSM states
// and the doubleword alignment mask.
package acesso_memoria_pkg;

  localparam logic [1:0] OP_PASS  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Op code 2'b11 is not a memory op, so it falls through to pass behaviour.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] low_bits);
    return (low_bits & ALIGN_MASK) != 3'b000;
  endfunction

endpackage

// File: rtl/acesso_memoria_contador.sv
// Bus-timeout counter: counts cycles while enabled and flags the last
// allowed cycle. A TIMEOUT of 0 never expires.
module contador_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/acesso_memoria.sv
// Memory-access stage: passes ALU results through, or performs one
// load/store over a req/ack port and returns a one-cycle writeback pulse.
module acesso_memoria
  import acesso_memoria_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault
);

  state_t            state;
  logic              lat_load;
  logic              lat_wr;
  logic [RD_W-1:0]   lat_rd;
  logic              waiting;
  logic              expire;

  assign in_ready = (state == IDLE);
  assign waiting  = (state == WAIT);

  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (waiting),
    .clear  (!waiting),
    .expire (expire)
  );

  // A reset in WAIT simply abandons the open request; no writeback follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_load  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      fault     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem_op(in_op)) begin
              wb_valid <= 1'b1;
              wb_we    <= in_wr;
              wb_rd    <= in_rd;
              wb_data  <= in_addr;
            end else if (is_misaligned(in_addr[2:0])) begin
              wb_valid <= 1'b1;
              fault    <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= in_rd;
              wb_data  <= in_addr;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= (in_op == OP_STORE);
              mem_addr  <= in_addr;
              mem_wdata <= in_data;
              lat_load  <= (in_op == OP_LOAD);
              lat_wr    <= in_wr;
              lat_rd    <= in_rd;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (mem_req && mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= lat_rd;
            wb_we    <= lat_load ? lat_wr : 1'b0;
            wb_data  <= lat_load ? mem_rdata : '0;
          end else if (expire) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            fault    <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= lat_rd;
            wb_data  <= mem_addr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acesso_memoria.sv
// Self-checking bench for acesso_memoria: directed scenarios plus random ops
// compared against a transaction-level model with a sparse memory image.
module tb_acesso_memoria;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int TO = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          in_wr;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          wb_valid;
  logic          wb_we;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          fault;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_model [logic [63:0]];

  acesso_memoria #(
    .DATA_W  (DW),
    .RD_W    (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .in_wr     (in_wr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete op: accept, act as the memory, then compare the writeback
  // against what the op should produce. ack_after = req cycle carrying the
  // ack (1 = immediate), 0 = memory never answers.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                               input logic [4:0] rd, input logic wr, input int ack_after);
    logic        is_mem, misal, is_load, completes, exp_fault, exp_we, chk_rd, seen;
    logic [63:0] exp_data;
    int          exp_cyc, exp_req, req_count, cyc;
    is_mem    = (op == 2'd1) || (op == 2'd2);
    is_load   = (op == 2'd1);
    misal     = (addr[2:0] != 3'd0);
    completes = (ack_after > 0) && (ack_after <= TO);
    if (is_mem && !misal && is_load && !mem_model.exists(addr))
      mem_model[addr] = {$urandom, $urandom};
    if (!is_mem) begin
      exp_cyc = 1; exp_req = 0; exp_fault = 1'b0; exp_we = wr; exp_data = addr; chk_rd = 1'b1;
    end else if (misal) begin
      exp_cyc = 1; exp_req = 0; exp_fault = 1'b1; exp_we = 1'b0; exp_data = addr; chk_rd = 1'b0;
    end else if (completes) begin
      exp_cyc = ack_after + 1; exp_req = ack_after; exp_fault = 1'b0;
      exp_we = is_load ? wr : 1'b0;
      exp_data = is_load ? mem_model[addr] : 64'd0;
      chk_rd = is_load;
    end else begin
      exp_cyc = TO + 1; exp_req = TO; exp_fault = 1'b1; exp_we = 1'b0; exp_data = addr; chk_rd = 1'b0;
    end

    @(negedge clk);
    checkOutput("idle_ready", 64'(in_ready), 64'd1);
    checkOutput("idle_wb_low", 64'(wb_valid), 64'd0);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_data = data; in_rd = rd; in_wr = wr;
    mem_ack  = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid  = 1'b0;
    req_count = 0;
    seen      = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (wb_valid) begin
        seen = 1'b1;
        break;
      end
      if (mem_req) begin
        req_count++;
        checkOutput("mem_addr", mem_addr, addr);
        checkOutput("mem_we", 64'(mem_we), 64'(op == 2'd2));
        checkOutput("mem_wdata", mem_wdata, data);
        mem_ack = (req_count == ack_after);
        if (mem_model.exists(mem_addr)) mem_rdata = mem_model[mem_addr];
        else mem_rdata = {$urandom, $urandom};
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checkOutput("wb_seen", 64'(seen), 64'd1);
    checkOutput("wb_latency", 64'(cyc), 64'(exp_cyc));
    checkOutput("req_cycles", 64'(req_count), 64'(exp_req));
    checkOutput("wb_fault", 64'(fault), 64'(exp_fault));
    checkOutput("wb_we", 64'(wb_we), 64'(exp_we));
    checkOutput("wb_data", wb_data, exp_data);
    checkOutput("wb_req_low", 64'(mem_req), 64'd0);
    checkOutput("wb_ready", 64'(in_ready), 64'd1);
    if (chk_rd) checkOutput("wb_rd", 64'(wb_rd), 64'(rd));
    if (is_mem && !misal && !is_load && completes) mem_model[addr] = data;
  endtask

  initial begin
    logic [63:0] pv [3];
    logic [1:0]  rop;
    logic [63:0] raddr;

    reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_addr = '0; in_data = '0;
    in_rd = '0; in_wr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_req", 64'(mem_req), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_fault", 64'(fault), 64'd0);
    checkOutput("rst_wb_data", wb_data, 64'd0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    reset = 1'b0;

    $display("[TB] directed scenarios");
    mem_model[64'h100] = 64'hDEAD_BEEF;
    applyStimulus(2'd0, 64'h1234, 64'h0, 5'd3, 1'b1, 0);
    applyStimulus(2'd1, 64'h100, 64'h0, 5'd7, 1'b1, 3);
    applyStimulus(2'd2, 64'h108, 64'h55, 5'd2, 1'b1, 1);
    applyStimulus(2'd1, 64'h108, 64'h0, 5'd8, 1'b1, 2);
    applyStimulus(2'd1, 64'h103, 64'h0, 5'd4, 1'b1, 1);
    applyStimulus(2'd2, 64'h10C, 64'h9, 5'd4, 1'b0, 1);
    applyStimulus(2'd1, 64'h200, 64'h0, 5'd9, 1'b1, 0);
    applyStimulus(2'd2, 64'h210, 64'h77, 5'd9, 1'b0, 0);
    applyStimulus(2'd1, 64'h208, 64'h0, 5'd10, 1'b1, TO);
    applyStimulus(2'd3, 64'hABCD_0007, 64'h0, 5'd11, 1'b0, 0);

    $display("[TB] back-to-back pass ops");
    for (int i = 0; i < 3; i++) pv[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checkOutput("pipe_valid", 64'(wb_valid), 64'd1);
        checkOutput("pipe_data", wb_data, pv[i-1]);
        checkOutput("pipe_ready", 64'(in_ready), 64'd1);
      end
      if (i < 3) begin
        in_valid = 1'b1; in_op = 2'd0; in_addr = pv[i]; in_rd = 5'(i + 1); in_wr = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    $display("[TB] upstream holds an op while a load is open");
    mem_model[64'h400] = 64'hCAFE_F00D;
    pv[0] = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_addr = 64'h400; in_rd = 5'd12; in_wr = 1'b1;
    @(negedge clk);
    checkOutput("hold_req", 64'(mem_req), 64'd1);
    checkOutput("hold_busy", 64'(in_ready), 64'd0);
    in_op = 2'd0; in_addr = pv[0]; in_rd = 5'd13;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("hold_no_wb", 64'(wb_valid), 64'd0);
    mem_ack = 1'b1; mem_rdata = mem_model[64'h400];
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("hold_load_wb", 64'(wb_valid), 64'd1);
    checkOutput("hold_load_data", wb_data, 64'hCAFE_F00D);
    checkOutput("hold_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("hold_pass_wb", 64'(wb_valid), 64'd1);
    checkOutput("hold_pass_data", wb_data, pv[0]);
    checkOutput("hold_pass_rd", 64'(wb_rd), 64'd13);

    $display("[TB] reset while a request is open");
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_addr = 64'h300; in_rd = 5'd14; in_wr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_ack = 1'b0;
    checkOutput("rstw_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstw_req_low", 64'(mem_req), 64'd0);
    checkOutput("rstw_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rstw_no_wb", 64'(wb_valid), 64'd0);
      @(negedge clk);
    end
    applyStimulus(2'd0, 64'h5A5A, 64'h0, 5'd15, 1'b1, 0);

    $display("[TB] random ops");
    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom_range(0, 3));
      if (rop == 2'd0 || rop == 2'd3) begin
        raddr = {$urandom, $urandom};
      end else begin
        raddr = 64'h1000 + 64'($urandom_range(0, 15)) * 64'd8;
        if ($urandom_range(0, 4) == 0) raddr = raddr + 64'($urandom_range(1, 7));
      end
      applyStimulus(rop, raddr, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
